// File: rtl/scan_encoder.sv
// Sequential set-bit encoder: accepts an N-bit request vector and emits the
// index of each set bit, one per output handshake, in LSB-first or round-robin order.
module scan_encoder #(
   parameter  int N           = 8,
   parameter  int ROUND_ROBIN = 0,
   localparam int IW          = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_vec,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          zero_err
);

   typedef enum logic {S_IDLE, S_EMIT} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N-1:0]    r_pending;
   logic [IW-1:0]   r_ptr;
   logic            r_zero_err;

   logic [IW-1:0]   w_sel_lo;
   logic [IW-1:0]   w_sel_hi;
   logic [IW-1:0]   w_sel;
   logic            w_found_hi;
   logic            w_single;
   logic            w_accept;
   logic            w_pop;

   // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_sel_lo   = '0;
      w_sel_hi   = '0;
      w_found_hi = 1'b0;
      // Scanning downward leaves the lowest matching index in each candidate.
      for (int i = N - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_sel_lo = IW'(i);
            if (i >= int'(r_ptr)) begin
               w_sel_hi   = IW'(i);
               w_found_hi = 1'b1;
            end
         end
      end
      w_sel = ((ROUND_ROBIN != 0) && w_found_hi) ? w_sel_hi : w_sel_lo;
   end

   assign w_single = (r_pending & (r_pending - N'(1))) == '0;
   assign w_accept = (r_state == S_IDLE) && in_valid;
   assign w_pop    = (r_state == S_EMIT) && out_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid && (in_vec != '0)) w_state_nxt = S_EMIT;
         S_EMIT:  if (out_ready && w_single)      w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending  <= '0;
         r_ptr      <= '0;
         r_zero_err <= 1'b0;
      end else begin
         r_zero_err <= w_accept && (in_vec == '0);
         if (w_accept) begin
            r_pending <= in_vec;
         end else if (w_pop) begin
            r_pending <= r_pending & ~(N'(1) << w_sel);
            if (ROUND_ROBIN != 0)
               r_ptr <= (w_sel == IW'(N - 1)) ? '0 : w_sel + 1'b1;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_EMIT);
   assign out_idx   = out_valid ? w_sel : '0;
   assign out_last  = out_valid && w_single;
   assign zero_err  = r_zero_err;

endmodule
